// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo engine: frame-state encoding and
// default serial timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } frame_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A push while full is accepted
// only when a pop happens in the same cycle; the read port is combinational.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; wrap is implicit in the pointer width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage array; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo engine: receives frames on rxd, queues good words in a FIFO and
// retransmits them on txd, with TX pause, sticky overflow and framing errors.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 echo_en,
    input  logic                 tx_pause,
    input  logic                 clr_ovf,
    input  logic                 rxd,
    output logic                 txd,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 tx_busy,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;

    frame_state_t         rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [IW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic [DATA_BITS-1:0] rx_word_n;
    logic                 rx_valid_n;
    logic                 framing_err_n;

    frame_state_t         tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [IW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 txd_n;
    logic                 pop;

    logic                 push_req;
    logic                 ovf_evt;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    // RX next-state: mid-bit sampling, glitch reject in START, stop-bit check.
    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt + CW'(1);
        rx_idx_n      = rx_idx;
        rx_shift_n    = rx_shift;
        rx_word_n     = rx_word;
        rx_valid_n    = 1'b0;
        framing_err_n = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_sync) rx_state_n = START;
            end
            START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == LAST_BIT) rx_state_n = STOP;
                    else                    rx_idx_n   = rx_idx + IW'(1);
                end
            end
            STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_state_n = IDLE;
                    if (rx_sync) begin
                        rx_word_n  = rx_shift;
                        rx_valid_n = 1'b1;
                    end else begin
                        framing_err_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // RX state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_idx      <= rx_idx_n;
            rx_word     <= rx_word_n;
            rx_valid    <= rx_valid_n;
            framing_err <= framing_err_n;
        end
    end

    // RX shift register is pure data and needs no reset.
    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_n;
    end

    assign push_req = rx_valid && echo_en;
    assign ovf_evt  = push_req && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (rx_word),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_count = CNT_W'(fifo_cnt);

    // Sticky overflow; a new drop wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)          overflow <= 1'b0;
        else if (ovf_evt) overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    // TX next-state: pop in IDLE, then start/data/stop bits of CLKS_PER_BIT each.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        pop        = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!fifo_empty && !tx_pause) begin
                    pop        = 1'b1;
                    tx_shift_n = fifo_dout;
                    txd_n      = 1'b0;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    txd_n      = tx_shift[0];
                    tx_shift_n = tx_shift >> 1;
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_idx == LAST_BIT) begin
                        txd_n      = 1'b1;
                        tx_state_n = STOP;
                    end else begin
                        txd_n      = tx_shift[0];
                        tx_shift_n = tx_shift >> 1;
                        tx_idx_n   = tx_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // TX state and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            txd      <= txd_n;
            tx_busy  <= (tx_state_n != IDLE);
        end
    end

    // TX shift register is pure data and needs no reset.
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_n;
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: drives serial frames, decodes txd independently
// and compares against a queue-based model of the echo path.
module tb_uart_echo_fifo;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             echo_en;
    logic             tx_pause;
    logic             clr_ovf;
    logic             rxd;
    logic             txd;
    logic [DB-1:0]    rx_word;
    logic             rx_valid;
    logic             framing_err;
    logic             tx_busy;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    int rv_cyc = 0;
    int busy_run = 0;
    int last_busy_run = 0;
    int tx_start_cyc = 0;
    int tx_bad = 0;

    logic [DB-1:0] tx_log[$];
    logic [DB-1:0] mq[$];
    logic          model_ovf;
    logic [DB-1:0] last_word;

    int            n0, rv0, fe0, lows, cnz;
    logic [DB-1:0] b;

    uart_echo_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo_en     (echo_en),
        .tx_pause    (tx_pause),
        .clr_ovf     (clr_ovf),
        .rxd         (rxd),
        .txd         (txd),
        .rx_word     (rx_word),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rv_cnt <= rv_cnt + 1;
            rv_cyc <= cyc;
        end
        if (framing_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (tx_busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else begin
            if (busy_run != 0) last_busy_run <= busy_run;
            busy_run <= 0;
        end
    end

    initial begin : tx_monitor
        logic [DB-1:0] sh;
        bit ab;
        bit sb;
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && rst === 1'b0) begin
                tx_start_cyc = cyc;
                ab = 0;
                sh = '0;
                repeat (CPB / 2) begin @(negedge clk); if (rst !== 1'b0) ab = 1; end
                sb = (txd !== 1'b0);
                for (int i = 0; i < DB; i++) begin
                    repeat (CPB) begin @(negedge clk); if (rst !== 1'b0) ab = 1; end
                    sh[i] = txd;
                end
                repeat (CPB) begin @(negedge clk); if (rst !== 1'b0) ab = 1; end
                if (!ab) begin
                    if (sb || txd !== 1'b1) tx_bad++;
                    tx_log.push_back(sh);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed no completion, required finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        if (stop_bit) last_word = data;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int bud = 0;
        while (tx_log.size() < n && bud < 200 * DB * CPB / 8 * 8 + 400) begin
            @(negedge clk);
            bud++;
        end
        chk(tag, tx_log.size(), n);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int bud = 0;
        while (tx_busy !== lvl && bud < 400) begin
            @(negedge clk);
            bud++;
        end
        chk(tag, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic wait_rx_valid(input string tag);
        int bud = 0;
        while (rx_valid !== 1'b1 && bud < 400) begin
            @(negedge clk);
            bud++;
        end
        chk(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic model_push(input logic [DB-1:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else                   model_ovf = 1'b1;
    endtask

    initial begin
        rst = 1'b1; echo_en = 1'b1; tx_pause = 1'b0; clr_ovf = 1'b0; rxd = 1'b1;
        model_ovf = 1'b0; last_word = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rx_word", 32'(rx_word), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_framing_err", 32'(framing_err), 32'd0);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single echo of 0x55: latency, frame content, busy length.
        n0 = tx_log.size(); rv0 = rv_cnt;
        send_frame(8'h55, 1'b1);
        wait_frames(n0 + 1, "t1_frame_count");
        repeat (20) @(negedge clk);
        chk("t1_rx_valid_pulses", rv_cnt - rv0, 1);
        chk("t1_rx_word", 32'(rx_word), 32'h55);
        chk("t1_start_latency", tx_start_cyc - rv_cyc, 2);
        if (tx_log.size() > n0) chk("t1_echo", 32'(tx_log[n0]), 32'h55);
        chk("t1_busy_cycles", last_busy_run, (DB + 2) * CPB);
        chk("t1_fifo_count", 32'(fifo_count), 32'd0);

        // Random words with random gaps, all echoed in order.
        n0 = tx_log.size(); mq.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            model_push(b);
            send_frame(b, 1'b1);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            if (mq.size() > 1) void'(mq.pop_front());
        end
        wait_frames(n0 + 6, "rand_frame_count");
        repeat (20) @(negedge clk);
        chk("rand_last_echo", 32'(tx_log[tx_log.size() - 1]), 32'(last_word));
        chk("rand_fifo_count", 32'(fifo_count), 32'd0);

        // Paused queue fills, overflow on the fifth word, clr/overflow collision.
        tx_pause = 1'b1; n0 = tx_log.size(); mq.delete(); model_ovf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            model_push(b);
            send_frame(b, 1'b1);
            repeat (4) @(negedge clk);
            chk("t2_fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("t2_overflow", 32'(overflow), 32'(model_ovf));
        end
        b = 8'($urandom_range(0, 255));
        model_push(b);
        fork
            send_frame(b, 1'b1);
            begin
                wait_rx_valid("t2_rx_valid_seen");
                clr_ovf = 1'b1;
                @(negedge clk);
                clr_ovf = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("t2_ovf_beats_clear", 32'(overflow), 32'(model_ovf));
        tx_pause = 1'b0;
        wait_frames(n0 + DEPTH, "t2_frame_count");
        repeat (400) @(negedge clk);
        chk("t2_no_extra_frames", tx_log.size(), n0 + DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (tx_log.size() > n0 + i) chk("t2_echo", 32'(tx_log[n0 + i]), 32'(mq[i]));
        chk("t2_overflow_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("t2_overflow_cleared", 32'(overflow), 32'd0);

        // Framing error: stop bit low.
        n0 = tx_log.size(); rv0 = rv_cnt; fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        repeat (300) @(negedge clk);
        chk("t3_framing_err_pulses", fe_cnt - fe0, 1);
        chk("t3_rx_valid_pulses", rv_cnt - rv0, 0);
        chk("t3_rx_word_kept", 32'(rx_word), 32'(last_word));
        chk("t3_fifo_count", 32'(fifo_count), 32'd0);
        chk("t3_no_tx", tx_log.size(), n0);

        // echo_en low: word received but never queued.
        echo_en = 1'b0; rv0 = rv_cnt;
        send_frame(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_rx_valid_pulses", rv_cnt - rv0, 1);
        chk("t4_rx_word", 32'(rx_word), 32'h7E);
        lows = 0; cnz = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
            if (fifo_count !== '0) cnz++;
        end
        chk("t4_txd_low_cycles", lows, 0);
        chk("t4_count_nonzero_cycles", cnz, 0);
        echo_en = 1'b1;

        // Full queue with pop coinciding with the push of 0x99.
        tx_pause = 1'b1; n0 = tx_log.size(); mq.delete(); model_ovf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            model_push(b);
            send_frame(b, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("t6_full_count", 32'(fifo_count), 32'(mq.size()));
        mq.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                wait_rx_valid("t6_rx_valid_seen");
                tx_pause = 1'b0;
            end
        join
        chk("t6_count_after_swap", 32'(fifo_count), 32'(mq.size() - 1));
        chk("t6_overflow", 32'(overflow), 32'(model_ovf));
        wait_frames(n0 + DEPTH + 1, "t6_frame_count");
        for (int i = 0; i <= DEPTH; i++)
            if (tx_log.size() > n0 + i) chk("t6_echo", 32'(tx_log[n0 + i]), 32'(mq[i]));
        repeat (200) @(negedge clk);

        // Reset 40 cycles into a frame with two words still queued.
        tx_pause = 1'b1; n0 = tx_log.size(); mq.delete(); model_ovf = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            model_push(b);
            send_frame(b, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("t5_overflow_before", 32'(overflow), 32'(model_ovf));
        tx_pause = 1'b0;
        wait_busy(1'b1, "t5_first_busy");
        wait_busy(1'b0, "t5_first_done");
        wait_busy(1'b1, "t5_second_busy");
        repeat (40) @(negedge clk);
        chk("t5_queued_before_reset", 32'(fifo_count), 32'(mq.size() - 2));
        if (tx_log.size() > n0) chk("t5_first_echo", 32'(tx_log[n0]), 32'(mq[0]));
        n0 = tx_log.size();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_txd", 32'(txd), 32'd1);
        chk("t5_tx_busy", 32'(tx_busy), 32'd0);
        chk("t5_fifo_count", 32'(fifo_count), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_rx_word", 32'(rx_word), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("t5_quiet_after_reset", lows, 0);
        chk("t5_no_frames_after_reset", tx_log.size(), n0);

        chk("tx_frame_shape", tx_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
